inst_fetch_queue: RTL and testbench

Fetch stage sitting directly downstream of the PC unit. Takes each fetch address the PC unit produces, issues a word read to instruction memory over a req/ack handshake, and buffers returned instructions with their PCs in a small FIFO. The FIFO feeds decode through a valid/ready interface. Back-pressures the PC unit via PcStall and flushes on a taken branch or jump (Redirect).

---
 rtl/inst_fetch_queue_if.sv | 33 +++
 rtl/inst_fetch_queue.sv | 172 +++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus interface.
// Bundles the PC-unit handshake, the instruction-memory req/ack port and the
// decode valid/ready port of inst_fetch_queue.
//   master : environment side (PC unit, instruction memory, decode)
//   slave  : inst_fetch_queue side
// Parameter CNT_W sets the width of Count (log2(DEPTH)+1).
interface inst_fetch_queue_if #(
    parameter int unsigned CNT_W = 3
);
    logic [31:0]      PC;
    logic             PcValid;
    logic             PcStall;
    logic             Redirect;
    logic             ImReq;
    logic [31:0]      ImAddr;
    logic             ImAck;
    logic [31:0]      ImData;
    logic             InstValid;
    logic [31:0]      Inst;
    logic [31:0]      InstPc;
    logic             InstReady;
    logic [CNT_W-1:0] Count;

    modport master (
        output PC, PcValid, Redirect, ImAck, ImData, InstReady,
        input  PcStall, ImReq, ImAddr, InstValid, Inst, InstPc, Count
    );

    modport slave (
        input  PC, PcValid, Redirect, ImAck, ImData, InstReady,
        output PcStall, ImReq, ImAddr, InstValid, Inst, InstPc, Count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue.
// Accepts fetch addresses from the PC unit, issues one word read at a time
// to instruction memory (req/ack), and buffers {instruction, PC} pairs in a
// DEPTH-entry FIFO that feeds decode through valid/ready. Redirect flushes
// the FIFO and drops any in-flight read.
// Ports:
//   Clk    : clock, rising edge
//   ReSet  : synchronous active-high reset
//   bus    : inst_fetch_queue_if.slave (PC, PcValid, PcStall, Redirect,
//            ImReq, ImAddr, ImAck, ImData, InstValid, Inst, InstPc,
//            InstReady, Count)
// Optional build macro FQ_BYPASS_EN: when the FIFO is empty, an ack in WAIT
// is presented to decode in the same cycle and, if consumed, not enqueued.
module inst_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input logic               Clk,
    input logic               ReSet,
    inst_fetch_queue_if.slave bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DROP
    } state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    state_t             state_q, state_d;
    logic               im_req_q, im_req_d;
    logic [31:0]        im_addr_q, im_addr_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];

    logic               full;
    logic               empty;
    logic               accept;
    logic               ack_push;
    logic               bypass;
    logic               fifo_push;
    logic               fifo_pop;
    entry_t             head_e;
    logic               pc_low_unused;

    // Address bits [1:0] are dropped by word alignment.
    always_comb pc_low_unused = ^bus.PC[1:0];

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == '0);
        head_e   = mem_q[head_q];
        accept   = (state_q == ST_IDLE) && bus.PcValid && !full && !bus.Redirect;
        ack_push = (state_q == ST_WAIT) && bus.ImAck && !bus.Redirect;
`ifdef FQ_BYPASS_EN
        bypass   = ack_push && empty;
`else
        bypass   = 1'b0;
`endif
        // A bypassed word taken by decode this cycle never enters the FIFO.
        fifo_push = ack_push && !(bypass && bus.InstReady);
        fifo_pop  = !empty && bus.InstReady && !bus.Redirect;
    end

    always_comb begin
        bus.PcStall   = !((state_q == ST_IDLE) && !full);
        bus.ImReq     = im_req_q;
        bus.ImAddr    = im_addr_q;
        bus.Count     = count_q;
        bus.InstValid = !empty || bypass;
        if (!empty) begin
            bus.Inst   = head_e.inst;
            bus.InstPc = head_e.pc;
        end else if (bypass) begin
            bus.Inst   = bus.ImData;
            bus.InstPc = im_addr_q;
        end else begin
            bus.Inst   = '0;
            bus.InstPc = '0;
        end
    end

    // Fetch FSM next state
    always_comb begin
        state_d   = state_q;
        im_req_d  = im_req_q;
        im_addr_d = im_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    im_addr_d = {bus.PC[31:2], 2'b00};
                    im_req_d  = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Redirect with ack discards the word and returns to IDLE;
                // redirect without ack must still wait out the read in DROP.
                if (bus.ImAck) begin
                    im_req_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (bus.Redirect) begin
                    state_d  = ST_DROP;
                end
            end
            ST_DROP: begin
                if (bus.ImAck) begin
                    im_req_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                im_req_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // FIFO next state
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.Redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (fifo_push) begin
                mem_d[tail_q] = '{inst: bus.ImData, pc: im_addr_q};
                tail_d        = tail_q + PTR_W'(1);
            end
            if (fifo_pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        end
    end

    always_ff @(posedge Clk) begin
        if (ReSet) begin
            state_q   <= ST_IDLE;
            im_req_q  <= 1'b0;
            im_addr_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            im_req_q  <= im_req_d;
            im_addr_q <= im_addr_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            mem_q     <= mem_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH=4).
// Expected values in bypass-sensitive steps follow FQ_BYPASS_EN.
module tb_inst_fetch_queue;

`ifdef FQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic Clk;
    logic ReSet;
    int   checks;
    int   failures;

    inst_fetch_queue_if #(.CNT_W(3)) bus ();

    inst_fetch_queue #(.DEPTH(4), .CNT_W(3)) dut (
        .Clk   (Clk),
        .ReSet (ReSet),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Zero-wait fetch: accept edge, then ack in the following cycle.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
        bus.PC      = addr;
        bus.PcValid = 1'b1;
        tick();
        bus.PcValid = 1'b0;
        chk("fetch_addr", bus.ImAddr, addr);
        bus.ImAck   = 1'b1;
        bus.ImData  = data;
        tick();
        bus.ImAck   = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        ReSet         = 1'b1;
        bus.PC        = '0;
        bus.PcValid   = 1'b0;
        bus.Redirect  = 1'b0;
        bus.ImAck     = 1'b0;
        bus.ImData    = '0;
        bus.InstReady = 1'b0;
        tick();
        tick();
        ReSet = 1'b0;

        // Reset state
        chk("rst_imreq",  bus.ImReq,     32'd0);
        chk("rst_imaddr", bus.ImAddr,    32'd0);
        chk("rst_count",  bus.Count,     32'd0);
        chk("rst_valid",  bus.InstValid, 32'd0);
        chk("rst_inst",   bus.Inst,      32'd0);
        chk("rst_instpc", bus.InstPc,    32'd0);
        chk("rst_stall",  bus.PcStall,   32'd0);

        // Single fetch, ack one cycle after ImReq rises
        bus.PC      = 32'h0000_3000;
        bus.PcValid = 1'b1;
        tick();
        bus.PcValid = 1'b0;
        chk("t1_imreq",  bus.ImReq,   32'd1);
        chk("t1_imaddr", bus.ImAddr,  32'h0000_3000);
        chk("t1_stall",  bus.PcStall, 32'd1);
        tick();
        chk("t1_hold",   bus.ImReq,   32'd1);
        bus.ImAck  = 1'b1;
        bus.ImData = 32'h2008_0005;
        #1;
        chk("t1_ackcyc_valid", bus.InstValid, {31'd0, BYP});
        tick();
        bus.ImAck = 1'b0;
        chk("t1_valid",  bus.InstValid, 32'd1);
        chk("t1_inst",   bus.Inst,      32'h2008_0005);
        chk("t1_instpc", bus.InstPc,    32'h0000_3000);
        chk("t1_count",  bus.Count,     32'd1);
        chk("t1_reqlow", bus.ImReq,     32'd0);
        bus.InstReady = 1'b1;
        tick();
        bus.InstReady = 1'b0;
        chk("t1_popcnt", bus.Count,     32'd0);
        chk("t1_popval", bus.InstValid, 32'd0);
        chk("t1_popins", bus.Inst,      32'd0);

        // Fill to full, stall, then drain in order
        for (int i = 0; i < 4; i++) begin
            fetch(32'h0000_3000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
        end
        chk("t2_count",  bus.Count,   32'd4);
        chk("t2_stall",  bus.PcStall, 32'd1);
        chk("t2_inst",   bus.Inst,    32'hA000_0000);
        chk("t2_instpc", bus.InstPc,  32'h0000_3000);
        bus.PC      = 32'h0000_3010;
        bus.PcValid = 1'b1;
        tick();
        bus.PcValid = 1'b0;
        chk("t2_noissue", bus.ImReq, 32'd0);
        chk("t2_fullcnt", bus.Count, 32'd4);
        bus.InstReady = 1'b1;
        tick();
        chk("t2_pop_cnt",   bus.Count,   32'd3);
        chk("t2_pop_stall", bus.PcStall, 32'd0);
        chk("t2_pop_inst",  bus.Inst,    32'hA000_0001);
        chk("t2_pop_pc",    bus.InstPc,  32'h0000_3004);
        tick();
        chk("t2_ord2", bus.Inst, 32'hA000_0002);
        tick();
        chk("t2_ord3", bus.Inst, 32'hA000_0003);
        tick();
        bus.InstReady = 1'b0;
        chk("t2_empty", bus.Count, 32'd0);

        // Redirect in WAIT before ack -> DROP, ack 3 cycles later
        bus.PC      = 32'h0000_5000;
        bus.PcValid = 1'b1;
        tick();
        bus.PcValid  = 1'b0;
        bus.Redirect = 1'b1;
        tick();
        bus.Redirect = 1'b0;
        chk("t3_drop_req",   bus.ImReq,   32'd1);
        chk("t3_drop_stall", bus.PcStall, 32'd1);
        tick();
        chk("t3_drop_hold",  bus.ImReq,   32'd1);
        chk("t3_drop_addr",  bus.ImAddr,  32'h0000_5000);
        tick();
        bus.ImAck   = 1'b1;
        bus.ImData  = 32'hDEAD_BEEF;
        bus.PC      = 32'h0000_9000;
        bus.PcValid = 1'b1;
        #1;
        chk("t3_drop_nobyp", bus.InstValid, 32'd0);
        tick();
        bus.ImAck   = 1'b0;
        bus.PcValid = 1'b0;
        chk("t3_reqlow", bus.ImReq,     32'd0);
        chk("t3_count",  bus.Count,     32'd0);
        chk("t3_valid",  bus.InstValid, 32'd0);
        chk("t3_stall",  bus.PcStall,   32'd0);
        fetch(32'h0000_4000, 32'h1111_2222);
        chk("t3_newpc",  bus.InstPc, 32'h0000_4000);
        chk("t3_newins", bus.Inst,   32'h1111_2222);
        chk("t3_newcnt", bus.Count,  32'd1);
        // Redirect in IDLE: flushes and ignores the same-cycle PcValid
        bus.Redirect = 1'b1;
        bus.PC       = 32'h0000_6000;
        bus.PcValid  = 1'b1;
        tick();
        bus.Redirect = 1'b0;
        bus.PcValid  = 1'b0;
        chk("t3_rd_flush", bus.Count, 32'd0);
        chk("t3_rd_noreq", bus.ImReq, 32'd0);

        // Simultaneous push/pop at Count=2 across pointer wrap
        fetch(32'h0000_0100, 32'hC0DE_0000);
        fetch(32'h0000_0104, 32'hC0DE_0001);
        chk("t4_count2", bus.Count, 32'd2);
        for (int i = 2; i < 12; i++) begin
            bus.PC      = 32'h0000_0100 + 32'(4 * i);
            bus.PcValid = 1'b1;
            tick();
            bus.PcValid   = 1'b0;
            bus.ImAck     = 1'b1;
            bus.ImData    = 32'hC0DE_0000 + 32'(i);
            bus.InstReady = 1'b1;
            tick();
            bus.ImAck     = 1'b0;
            bus.InstReady = 1'b0;
            chk("t4_pp_count", bus.Count,  32'd2);
            chk("t4_pp_inst",  bus.Inst,   32'hC0DE_0000 + 32'(i - 1));
            chk("t4_pp_pc",    bus.InstPc, 32'h0000_0100 + 32'(4 * (i - 1)));
        end

        // Reset in WAIT with Count=3
        fetch(32'h0000_0200, 32'hC0DE_0099);
        chk("t5_count3", bus.Count, 32'd3);
        bus.PC      = 32'h0000_0204;
        bus.PcValid = 1'b1;
        tick();
        bus.PcValid = 1'b0;
        chk("t5_wait", bus.ImReq, 32'd1);
        ReSet = 1'b1;
        tick();
        ReSet = 1'b0;
        chk("t5_imreq", bus.ImReq,     32'd0);
        chk("t5_count", bus.Count,     32'd0);
        chk("t5_valid", bus.InstValid, 32'd0);
        chk("t5_stall", bus.PcStall,   32'd0);
        chk("t5_inst",  bus.Inst,      32'd0);

        // Empty FIFO, ack with decode ready
        bus.PC      = 32'h0000_0700;
        bus.PcValid = 1'b1;
        tick();
        bus.PcValid   = 1'b0;
        bus.ImAck     = 1'b1;
        bus.ImData    = 32'h0800_0C00;
        bus.InstReady = 1'b1;
        #1;
        chk("t6_byp_valid", bus.InstValid, {31'd0, BYP});
        chk("t6_byp_inst",  bus.Inst,      BYP ? 32'h0800_0C00 : 32'd0);
        chk("t6_byp_pc",    bus.InstPc,    BYP ? 32'h0000_0700 : 32'd0);
        tick();
        bus.ImAck     = 1'b0;
        bus.InstReady = 1'b0;
        chk("t6_count", bus.Count,     BYP ? 32'd0 : 32'd1);
        chk("t6_valid", bus.InstValid, BYP ? 32'd0 : 32'd1);
        chk("t6_inst",  bus.Inst,      BYP ? 32'd0 : 32'h0800_0C00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
